// File: rtl/theater_pkg.sv
// theater_pkg: shared mode and state encodings for the cue sequencer
package theater_pkg;
    localparam logic [1:0] MODE_PLAY    = 2'b00;
    localparam logic [1:0] MODE_MUSIC   = 2'b01;
    localparam logic [1:0] MODE_SPEAKER = 2'b10;
    localparam logic [1:0] MODE_HOUSE   = 2'b11;
    typedef enum logic [2:0] {IDLE, GAP, RUN, DONE, EMERG} state_t;
endpackage

// File: rtl/theater_cue_mem.sv
// theater_cue_mem: cue register file, gated sync write, sync clear, two async read ports
// ports: clk/rst; we+wen gate a write of wmode/wdur to waddr;
//        cur_addr -> cur_mode/cur_dur, nxt_addr -> nxt_dur
module theater_cue_mem
    import theater_pkg::*;
#(
    parameter int NUM_CUES = 8,
    parameter int DUR_W    = 8,
    parameter int IDX_W    = $clog2(NUM_CUES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             wen,
    input  logic [IDX_W-1:0] waddr,
    input  logic [1:0]       wmode,
    input  logic [DUR_W-1:0] wdur,
    input  logic [IDX_W-1:0] cur_addr,
    input  logic [IDX_W-1:0] nxt_addr,
    output logic [1:0]       cur_mode,
    output logic [DUR_W-1:0] cur_dur,
    output logic [DUR_W-1:0] nxt_dur
);
    logic [1:0]       mode_q [NUM_CUES];
    logic [DUR_W-1:0] dur_q  [NUM_CUES];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CUES; i++) begin
                mode_q[i] <= MODE_PLAY;
                dur_q[i]  <= '0;
            end
        end else if (we && wen) begin
            mode_q[waddr] <= wmode;
            dur_q[waddr]  <= wdur;
        end
    end
    assign cur_mode = mode_q[cur_addr];
    assign cur_dur  = dur_q[cur_addr];
    assign nxt_dur  = dur_q[nxt_addr];
endmodule

// File: rtl/theater_cue_sequencer.sv
// theater_cue_sequencer: timed cue-list show controller driving theater mode inputs
// ports: clk/rst; prog_* program a cue slot (IDLE/DONE only); start/pause/abort/emerg control;
//        SysEN, PM/MM/SM/HM mode switches, busy, done, cue_idx status
module theater_cue_sequencer
    import theater_pkg::*;
#(
    parameter int NUM_CUES = 8,
    parameter int DUR_W    = 8,
    parameter int GAP_CYC  = 2,
    parameter int IDX_W    = $clog2(NUM_CUES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [IDX_W-1:0] prog_addr,
    input  logic [1:0]       prog_mode,
    input  logic [DUR_W-1:0] prog_dur,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             emerg,
    output logic             SysEN,
    output logic             PM,
    output logic             MM,
    output logic             SM,
    output logic             HM,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] cue_idx
);
    localparam logic [DUR_W-1:0] GAP_LD = DUR_W'(GAP_CYC - 1);
    state_t           state, nstate;
    logic [DUR_W-1:0] cnt, ncnt;
    logic [IDX_W-1:0] nidx;
    logic [1:0]       cur_mode;
    logic [DUR_W-1:0] cur_dur, nxt_dur;
    logic             idle_like;
    assign idle_like = (state == IDLE) || (state == DONE);
    // in IDLE/DONE the current port looks at cue 0 so a start sees the pre-write entry
    theater_cue_mem #(.NUM_CUES(NUM_CUES), .DUR_W(DUR_W), .IDX_W(IDX_W)) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we       (prog_we),
        .wen      (idle_like),
        .waddr    (prog_addr),
        .wmode    (prog_mode),
        .wdur     (prog_dur),
        .cur_addr (idle_like ? '0 : cue_idx),
        .nxt_addr (cue_idx + IDX_W'(1)),
        .cur_mode (cur_mode),
        .cur_dur  (cur_dur),
        .nxt_dur  (nxt_dur)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cue_idx <= '0;
        end else begin
            state   <= nstate;
            cnt     <= ncnt;
            cue_idx <= nidx;
        end
    end
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        nidx   = cue_idx;
        if (emerg) begin
            nstate = EMERG;
        end else if (state == EMERG || (abort && state != IDLE)) begin
            nstate = IDLE;
            nidx   = '0;
        end else if (idle_like) begin
            if (start) begin
                nidx   = '0;
                nstate = (cur_dur != '0) ? GAP : DONE;
                ncnt   = GAP_LD;
            end
        end else if (!pause) begin
            if (cnt != '0) begin
                ncnt = cnt - DUR_W'(1);
            end else if (state == GAP) begin
                nstate = RUN;
                ncnt   = cur_dur - DUR_W'(1);
            end else if (cue_idx == IDX_W'(NUM_CUES - 1) || nxt_dur == '0) begin
                nstate = DONE;
            end else begin
                nidx   = cue_idx + IDX_W'(1);
                nstate = GAP;
                ncnt   = GAP_LD;
            end
        end
    end
    assign SysEN = state != IDLE;
    assign PM    = state == RUN && cur_mode == MODE_PLAY;
    assign MM    = state == RUN && cur_mode == MODE_MUSIC;
    assign SM    = state == RUN && cur_mode == MODE_SPEAKER;
    assign HM    = state == EMERG || (state == RUN && cur_mode == MODE_HOUSE);
    assign busy  = state == GAP || state == RUN;
    assign done  = state == DONE;
endmodule

// File: tb/tb_theater_cue_sequencer.sv
// tb_theater_cue_sequencer: directed self-checking bench for theater_cue_sequencer
module tb_theater_cue_sequencer;
    logic       clk = 0;
    logic       rst = 1;
    logic       prog_we = 0;
    logic [2:0] prog_addr = 0;
    logic [1:0] prog_mode = 0;
    logic [7:0] prog_dur = 0;
    logic       start = 0, pause = 0, abort = 0, emerg = 0;
    logic       SysEN, PM, MM, SM, HM, busy, done;
    logic [2:0] cue_idx;
    logic [6:0] o;
    int         total = 0, passed = 0;
    // {SysEN,PM,MM,SM,HM,busy,done}
    localparam logic [6:0] V_IDLE = 7'b0000000;
    localparam logic [6:0] V_GAP  = 7'b1000010;
    localparam logic [6:0] V_PM   = 7'b1100010;
    localparam logic [6:0] V_MM   = 7'b1010010;
    localparam logic [6:0] V_SM   = 7'b1001010;
    localparam logic [6:0] V_HR   = 7'b1000110;
    localparam logic [6:0] V_DONE = 7'b1000001;
    localparam logic [6:0] V_EM   = 7'b1000100;
    theater_cue_sequencer #(.NUM_CUES(8), .DUR_W(8), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_mode(prog_mode), .prog_dur(prog_dur), .start(start), .pause(pause),
        .abort(abort), .emerg(emerg), .SysEN(SysEN), .PM(PM), .MM(MM), .SM(SM),
        .HM(HM), .busy(busy), .done(done), .cue_idx(cue_idx)
    );
    assign o = {SysEN, PM, MM, SM, HM, busy, done};
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic prog(input logic [2:0] a, input logic [1:0] m, input logic [7:0] d);
        prog_we = 1; prog_addr = a; prog_mode = m; prog_dur = d;
        step();
        prog_we = 0;
    endtask
    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask
    task automatic do_abort();
        abort = 1;
        step();
        abort = 0;
        total++;
        if (o !== V_IDLE || cue_idx !== 3'd0)
            $display("FAIL abort_idle: outs=%b idx=%0d want %b idx=0", o, cue_idx, V_IDLE);
        else passed++;
    endtask
    task automatic test_reset();
        do_reset();
        total++;
        if (o !== V_IDLE || cue_idx !== 3'd0)
            $display("FAIL reset: outs=%b idx=%0d want %b idx=0", o, cue_idx, V_IDLE);
        else passed++;
    endtask
    task automatic test_normal();
        logic [6:0] ev [11];
        logic [2:0] ei [11];
        ev = '{V_GAP, V_GAP, V_MM, V_MM, V_MM, V_GAP, V_GAP, V_SM, V_SM, V_DONE, V_DONE};
        ei = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        prog(3'd0, 2'b01, 8'd3);
        prog(3'd1, 2'b10, 8'd2);
        start = 1;
        for (int i = 0; i < 11; i++) begin
            step();
            start = 0;
            total++;
            if (o !== ev[i] || cue_idx !== ei[i])
                $display("FAIL normal[%0d]: outs=%b idx=%0d want %b idx=%0d", i, o, cue_idx, ev[i], ei[i]);
            else passed++;
        end
        do_abort();
    endtask
    task automatic test_pause();
        start = 1;
        step();
        start = 0;
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) pause = 1;
            if (i == 6) pause = 0;
            total++;
            if (o !== (i < 7 ? V_MM : V_GAP))
                $display("FAIL pause[%0d]: outs=%b want %b", i, o, (i < 7 ? V_MM : V_GAP));
            else passed++;
            step();
        end
        do_abort();
    endtask
    task automatic test_emerg();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 7; i++) step();
        total++;
        if (o !== V_SM || cue_idx !== 3'd1)
            $display("FAIL emerg_pre: outs=%b idx=%0d want %b idx=1", o, cue_idx, V_SM);
        else passed++;
        emerg = 1;
        step();
        total++;
        if (o !== V_EM) $display("FAIL emerg_on: outs=%b want %b", o, V_EM);
        else passed++;
        start = 1;
        step();
        start = 0;
        total++;
        if (o !== V_EM) $display("FAIL emerg_start: outs=%b want %b", o, V_EM);
        else passed++;
        emerg = 0;
        step();
        total++;
        if (o !== V_IDLE || cue_idx !== 3'd0)
            $display("FAIL emerg_off: outs=%b idx=%0d want %b idx=0", o, cue_idx, V_IDLE);
        else passed++;
        step();
        total++;
        if (o !== V_IDLE) $display("FAIL emerg_stay_idle: outs=%b want %b", o, V_IDLE);
        else passed++;
    endtask
    task automatic test_empty();
        do_reset();
        start = 1;
        step();
        start = 0;
        total++;
        if (o !== V_DONE) $display("FAIL empty_done: outs=%b want %b", o, V_DONE);
        else passed++;
        do_abort();
        prog(3'd0, 2'b00, 8'd3);
        start = 1;
        step();
        start = 0;
        step();
        step();
        total++;
        if (o !== V_PM) $display("FAIL play_run: outs=%b want %b", o, V_PM);
        else passed++;
        prog(3'd1, 2'b00, 8'd5);
        step();
        step();
        total++;
        if (o !== V_DONE || cue_idx !== 3'd0)
            $display("FAIL run_write_ignored: outs=%b idx=%0d want %b idx=0", o, cue_idx, V_DONE);
        else passed++;
        do_abort();
    endtask
    task automatic test_all();
        do_reset();
        for (int i = 0; i < 8; i++) prog(3'(i), 2'b11, 8'd1);
        start = 1;
        for (int i = 0; i < 24; i++) begin
            step();
            start = 0;
            total++;
            if (o !== (i % 3 == 2 ? V_HR : V_GAP) || cue_idx !== 3'(i / 3))
                $display("FAIL all[%0d]: outs=%b idx=%0d want %b idx=%0d", i, o, cue_idx,
                         (i % 3 == 2 ? V_HR : V_GAP), i / 3);
            else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (o !== V_DONE || cue_idx !== 3'd7)
                $display("FAIL all_done[%0d]: outs=%b idx=%0d want %b idx=7", i, o, cue_idx, V_DONE);
            else passed++;
        end
        do_abort();
    endtask
    task automatic test_rst_gap();
        prog(3'd0, 2'b01, 8'd3);
        start = 1;
        step();
        start = 0;
        total++;
        if (o !== V_GAP) $display("FAIL rst_gap_pre: outs=%b want %b", o, V_GAP);
        else passed++;
        rst = 1;
        step();
        rst = 0;
        total++;
        if (o !== V_IDLE || cue_idx !== 3'd0)
            $display("FAIL rst_gap: outs=%b idx=%0d want %b idx=0", o, cue_idx, V_IDLE);
        else passed++;
        start = 1;
        step();
        start = 0;
        total++;
        if (o !== V_DONE) $display("FAIL rst_cleared: outs=%b want %b", o, V_DONE);
        else passed++;
    endtask
    initial begin
        test_reset();
        test_normal();
        test_pause();
        test_emerg();
        test_empty();
        test_all();
        test_rst_gap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
